cell_balance_ctrl: RTL and testbench
====================================

// Module: cell_balance_ctrl
// PURPOSE
//  Parametrised passive-balancing controller for an N-cell series stack.
//  Snapshots all cell voltages, finds the pack minimum by sequential scan, and bleeds
//  every cell whose excess over the minimum exceeds a hysteretic threshold.
//  Bleeding runs for a fixed dwell, then all bleeders are off for a settle window
//  before the next measurement. Sits between the ADC sequencer and the bleed drivers.
// PARAMETERS
//  N_CELLS       8     number of series cells (>=2)
//  VW            12    cell voltage width, unsigned ADC code
//  DELTA_ON      12'd8 excess over min that starts balancing a cell
//  DELTA_OFF     12'd3 excess below which a previously balanced cell stops (<=DELTA_ON)
//  DWELL_CYCLES  1000  clocks bleeders stay on per period (>=1)
//  SETTLE_CYCLES 200   clocks bleeders are forced off before next measurement (>=1)
// PORTS
//  clk         in   1           clock
//  rst_n       in   1           reset, synchronous, active-low
//  en          in   1           balancing enable
//  fault       in   1           pack fault inhibit (OV/UV/OT from protection)
//  meas_valid  in   1           cell_v holds a fresh, coherent set this cycle
//  cell_v      in   N_CELLS*VW  flattened voltages, cell i = cell_v[i*VW +: VW]
//  balance     out  N_CELLS     bleed enable per cell, registered
//  v_min       out  VW          minimum of the last snapshot, registered
//  busy        out  1           state != IDLE
//  period_done out  1           one-cycle pulse on SETTLE->IDLE
// BEHAVIOUR
//  Reset: balance=0, v_min=0, busy=0, period_done=0, prev_mask=0, state=IDLE, counters=0.
//  FSM states IDLE, SCAN, DECIDE, BALANCE, SETTLE:
//   IDLE:    en && !fault && meas_valid -> latch cell_v into snapshot, idx=0, SCAN.
//            meas_valid ignored in every other state.
//   SCAN:    one cell per cycle, running min over idx 0..N_CELLS-1; N_CELLS cycles.
//   DECIDE:  1 cycle. diff_i = snap_i - v_min (VW bits, unsigned, never negative).
//            mask_i = (diff_i >= DELTA_ON) | (prev_mask_i & diff_i >= DELTA_OFF).
//            mask==0 -> IDLE (prev_mask<=0, no pulse); else balance<=mask,
//            prev_mask<=mask, dwell counter loaded, BALANCE.
//   BALANCE: balance held DWELL_CYCLES cycles, then balance<=0, SETTLE.
//   SETTLE:  balance=0 for SETTLE_CYCLES cycles, then period_done=1, IDLE.
//  Latency: meas_valid sampled at edge k -> balance visible after edge k+N_CELLS+2.
//  Equal minima: any cell equal to v_min has diff 0, never balanced; all equal -> mask 0.
//  Multiple cells may balance simultaneously; no cap.
//  fault=1 in any state: at next edge balance=0, state=IDLE, counters cleared,
//  prev_mask cleared. Has priority over en and over all state transitions.
//  en=0 in any state: same as fault except prev_mask retained.
//  Reset mid-period: returns to reset values at that edge regardless of state.
//  v_min updates only at end of SCAN; holds through BALANCE/SETTLE/IDLE.
//  Counters sized $clog2(max(DWELL_CYCLES,SETTLE_CYCLES)+1); no wrap.
// STRUCTURE
//  Package bms_pkg: state enum bal_state_t, VW default, cell index width function.
//  Sub-module cell_min_scan: sequential min finder (start, data, idx, done, min).
//  Top holds FSM, snapshot register, mask logic, dwell/settle counter.
// TESTING (bench N_CELLS=4, VW=12, DELTA_ON=8, DELTA_OFF=3, DWELL=10, SETTLE=5)
//  V={1000,1010,1005,1002}, meas_valid pulse -> after 6 edges balance=4'b0010, v_min=1000,
//   held 10 cycles, 0 for 5, period_done pulse.
//  Next period V={1000,1004,1009,1000} -> balance=4'b0110 (cell1 via hysteresis, cell2 new).
//  V all 2000 -> mask 0, return to IDLE after DECIDE, no period_done, balance stays 0.
//  fault asserted mid-BALANCE -> balance=0 next edge, busy=0; new period from fresh
//   V={1000,1004,...} does not re-balance cell1 (prev_mask cleared).
//  meas_valid toggled during SCAN/BALANCE with different V -> ignored, result unchanged.
//  rst_n low mid-SETTLE for 1 cycle -> all outputs at reset values next edge.

Source files
------------

// File: rtl/bms_pkg.sv
// rtl/bms_pkg.sv - shared types and helpers for the cell balancing controller
package bms_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DECIDE,
    ST_BALANCE,
    ST_SETTLE
  } bal_state_t;

  localparam int VW_DEFAULT = 12;

  // Width of a cell index; never below 1 bit so a 2-cell stack still has an index.
  function automatic int idx_width(input int n_cells);
    return (n_cells <= 2) ? 1 : $clog2(n_cells);
  endfunction

endpackage

// File: rtl/cell_min_scan.sv
// rtl/cell_min_scan.sv - sequential minimum finder, one cell per clock
module cell_min_scan
  import bms_pkg::*;
#(
  parameter int N_CELLS = 8,
  parameter int VW      = VW_DEFAULT,
  parameter int IW      = idx_width(N_CELLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [VW-1:0] data,
  output logic [IW-1:0] idx,
  output logic          done,
  output logic [VW-1:0] min
);

  logic active;

  // Walk idx 0..N_CELLS-1 after start, keeping the running minimum; done pulses once at the end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active <= 1'b0;
      idx    <= '0;
      done   <= 1'b0;
      min    <= '0;
    end else if (start) begin
      active <= 1'b1;
      idx    <= '0;
      done   <= 1'b0;
    end else if (active) begin
      if ((idx == '0) || (data < min)) begin
        min <= data;
      end
      if (idx == IW'(N_CELLS - 1)) begin
        active <= 1'b0;
        done   <= 1'b1;
      end else begin
        idx <= idx + IW'(1);
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/cell_balance_ctrl.sv
// rtl/cell_balance_ctrl.sv - passive balancing controller: snapshot, min scan, hysteretic bleed, dwell and settle
module cell_balance_ctrl
  import bms_pkg::*;
#(
  parameter int            N_CELLS       = 8,
  parameter int            VW            = VW_DEFAULT,
  parameter logic [VW-1:0] DELTA_ON      = 8,
  parameter logic [VW-1:0] DELTA_OFF     = 3,
  parameter int            DWELL_CYCLES  = 1000,
  parameter int            SETTLE_CYCLES = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fault,
  input  logic                  meas_valid,
  input  logic [N_CELLS*VW-1:0] cell_v,
  output logic [N_CELLS-1:0]    balance,
  output logic [VW-1:0]         v_min,
  output logic                  busy,
  output logic                  period_done
);

  localparam int CNT_MAX = (DWELL_CYCLES > SETTLE_CYCLES) ? DWELL_CYCLES : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = idx_width(N_CELLS);

  bal_state_t state, state_d;

  logic [N_CELLS*VW-1:0] snap;
  logic [VW-1:0]         v_min_d;
  logic [N_CELLS-1:0]    balance_d;
  logic [N_CELLS-1:0]    prev_mask, prev_mask_d;
  logic [N_CELLS-1:0]    mask;
  logic                  period_done_d;
  logic [CW-1:0]         cnt, cnt_d;

  logic                  scan_start;
  logic                  scan_done;
  logic [IW-1:0]         scan_idx;
  logic [VW-1:0]         scan_data;
  logic [VW-1:0]         scan_min;

  assign busy      = (state != ST_IDLE);
  assign scan_data = snap[int'(scan_idx)*VW +: VW];

  cell_min_scan #(
    .N_CELLS (N_CELLS),
    .VW      (VW),
    .IW      (IW)
  ) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .start (scan_start),
    .data  (scan_data),
    .idx   (scan_idx),
    .done  (scan_done),
    .min   (scan_min)
  );

  // Hold the coherent voltage set taken when a period starts; later meas_valid pulses never touch it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap <= '0;
    end else if (scan_start) begin
      snap <= cell_v;
    end
  end

  // Per-cell bleed decision: excess over the minimum against the on threshold, or the lower off threshold if already bleeding.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      mask[i] = ((snap[i*VW +: VW] - v_min) >= DELTA_ON) |
                (prev_mask[i] & ((snap[i*VW +: VW] - v_min) >= DELTA_OFF));
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      v_min       <= '0;
      balance     <= '0;
      prev_mask   <= '0;
      period_done <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_d;
      v_min       <= v_min_d;
      balance     <= balance_d;
      prev_mask   <= prev_mask_d;
      period_done <= period_done_d;
      cnt         <= cnt_d;
    end
  end

  // Next-state and output logic; fault outranks en, and both outrank every normal transition.
  always_comb begin
    state_d       = state;
    v_min_d       = v_min;
    balance_d     = balance;
    prev_mask_d   = prev_mask;
    period_done_d = 1'b0;
    cnt_d         = cnt;
    scan_start    = 1'b0;

    if (fault) begin
      state_d     = ST_IDLE;
      balance_d   = '0;
      prev_mask_d = '0;
      cnt_d       = '0;
    end else if (!en) begin
      state_d   = ST_IDLE;
      balance_d = '0;
      cnt_d     = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (meas_valid) begin
            scan_start = 1'b1;
            state_d    = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (scan_done) begin
            v_min_d = scan_min;
            state_d = ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          if (mask == '0) begin
            prev_mask_d = '0;
            state_d     = ST_IDLE;
          end else begin
            balance_d   = mask;
            prev_mask_d = mask;
            cnt_d       = CW'(DWELL_CYCLES - 1);
            state_d     = ST_BALANCE;
          end
        end
        ST_BALANCE: begin
          if (cnt == '0) begin
            balance_d = '0;
            cnt_d     = CW'(SETTLE_CYCLES - 1);
            state_d   = ST_SETTLE;
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            period_done_d = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          balance_d = '0;
          cnt_d     = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cell_balance_ctrl.sv
// tb/tb_cell_balance_ctrl.sv - scoreboard bench for cell_balance_ctrl
module tb_cell_balance_ctrl;

  localparam int N      = 4;
  localparam int VW     = 12;
  localparam int DWELL  = 10;
  localparam int SETTLE = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b1;
  logic            fault = 1'b0;
  logic            meas_valid = 1'b0;
  logic [N*VW-1:0] cell_v = '0;
  logic [N-1:0]    balance;
  logic [VW-1:0]   v_min;
  logic            busy;
  logic            period_done;

  typedef struct {
    logic [N-1:0]  mask;
    logic [VW-1:0] vmin;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] model_prev = '0;
  int           n_vec = 0;
  int           n_err = 0;

  cell_balance_ctrl #(
    .N_CELLS       (N),
    .VW            (VW),
    .DELTA_ON      (12'd8),
    .DELTA_OFF     (12'd3),
    .DWELL_CYCLES  (DWELL),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .fault       (fault),
    .meas_valid  (meas_valid),
    .cell_v      (cell_v),
    .balance     (balance),
    .v_min       (v_min),
    .busy        (busy),
    .period_done (period_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [N*VW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {VW'(d), VW'(c), VW'(b), VW'(a)};
  endfunction

  function automatic exp_t model(input logic [N*VW-1:0] v, input logic [N-1:0] pm);
    exp_t          e;
    logic [VW-1:0] d;
    e.vmin = v[VW-1:0];
    for (int i = 1; i < N; i++) if (v[i*VW +: VW] < e.vmin) e.vmin = v[i*VW +: VW];
    for (int i = 0; i < N; i++) begin
      d = v[i*VW +: VW] - e.vmin;
      e.mask[i] = (d >= 8) || (pm[i] && d >= 3);
    end
    return e;
  endfunction

  task automatic launch(input logic [N*VW-1:0] v, input bit noise, output logic [N-1:0] m);
    exp_t e;
    e = model(v, model_prev);
    model_prev = e.mask;
    sb.push_back(e);
    @(posedge clk); #1;
    cell_v = v;
    meas_valid = 1'b1;
    @(posedge clk); #1;
    meas_valid = noise;
    cell_v = noise ? pack4(10, 3000, 3000, 3000) : v;
    for (int c = 0; c <= N; c++) begin
      @(posedge clk); #1;
      meas_valid = noise && (c < 1);
    end
    @(negedge clk);
    chk("latency_early_balance", 32'(balance), 32'd0);
    chk("decide_busy", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      m = '0;
    end else begin
      e = sb.pop_front();
      chk("balance", 32'(balance), 32'(e.mask));
      chk("v_min", 32'(v_min), 32'(e.vmin));
      chk("busy_after_decide", 32'(busy), 32'(e.mask != '0));
      m = e.mask;
    end
  endtask

  task automatic finish_period(input logic [N-1:0] m, input bit noise);
    int hold = 1;
    int st = 0;
    int guard = 0;
    if (noise) begin
      meas_valid = 1'b1;
      cell_v = pack4(5, 900, 900, 900);
    end
    while (balance == m && guard < 40) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
      if (balance == m) hold++;
    end
    meas_valid = 1'b0;
    chk("dwell_cycles", 32'(hold), 32'(DWELL));
    guard = 0;
    while (balance == '0 && !period_done && guard < 40) begin
      st++;
      guard++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("settle_cycles", 32'(st), 32'(SETTLE));
    chk("period_done_pulse", 32'(period_done), 32'd1);
    chk("settle_balance", 32'(balance), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("period_done_once", 32'(period_done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] m;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_balance", 32'(balance), 32'd0);
    chk("reset_v_min", 32'(v_min), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_period_done", 32'(period_done), 32'd0);
    rst_n = 1'b1;

    // Basic period with meas_valid noise in SCAN and BALANCE.
    launch(pack4(1000, 1010, 1005, 1002), 1'b1, m);
    chk("p1_mask_const", 32'(m), 32'h2);
    finish_period(m, 1'b1);

    // Hysteresis keeps cell1, cell2 newly above threshold.
    launch(pack4(1000, 1004, 1009, 1000), 1'b0, m);
    chk("p2_mask_const", 32'(m), 32'h6);
    finish_period(m, 1'b0);

    // All equal: nothing to bleed, straight back to IDLE.
    launch(pack4(2000, 2000, 2000, 2000), 1'b0, m);
    @(posedge clk);
    @(negedge clk);
    chk("equal_no_pulse", 32'(period_done), 32'd0);
    chk("equal_balance", 32'(balance), 32'd0);

    // Fault mid-BALANCE clears prev_mask.
    launch(pack4(1000, 1010, 1005, 1002), 1'b0, m);
    repeat (3) @(posedge clk);
    #1 fault = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("fault_balance", 32'(balance), 32'd0);
    chk("fault_busy", 32'(busy), 32'd0);
    fault = 1'b0;
    model_prev = '0;
    launch(pack4(1000, 1004, 1009, 1000), 1'b0, m);
    chk("post_fault_mask_const", 32'(m), 32'h4);
    finish_period(m, 1'b0);

    // en drop mid-BALANCE retains prev_mask.
    launch(pack4(1000, 1010, 1005, 1002), 1'b0, m);
    repeat (2) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("en_off_balance", 32'(balance), 32'd0);
    chk("en_off_busy", 32'(busy), 32'd0);
    en = 1'b1;
    launch(pack4(1000, 1004, 1009, 1000), 1'b0, m);
    chk("post_en_mask_const", 32'(m), 32'h6);
    finish_period(m, 1'b0);

    // Reset pulse mid-SETTLE.
    launch(pack4(1000, 1004, 1009, 1000), 1'b0, m);
    repeat (DWELL + 2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_balance", 32'(balance), 32'd0);
    chk("rst_mid_v_min", 32'(v_min), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_period_done", 32'(period_done), 32'd0);
    rst_n = 1'b1;
    model_prev = '0;
    launch(pack4(1000, 1004, 1009, 1000), 1'b0, m);
    finish_period(m, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
